apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The module SHALL have parameter ADDR_WIDTH, default 32, meaning the paddr/cmd_addr width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, meaning the data width; the strobe width SHALL be DATA_WIDTH/8.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 16, meaning the number of ACCESS cycles allowed without pready before abort.
REQ-004 The module SHALL have port pclk, input, width 1, meaning the single clock; all logic is on the rising edge.
REQ-005 The module SHALL have port preset, input, width 1, meaning a synchronous, active-high reset.
REQ-006 The module SHALL have port cmd_valid, input, width 1, meaning a request is offered.
REQ-007 The module SHALL have port cmd_ready, output, width 1, meaning the request is accepted this cycle.
REQ-008 The module SHALL have port cmd_addr, input, width ADDR_WIDTH, meaning the transfer address.
REQ-009 The module SHALL have port cmd_write, input, width 1, meaning 1 = write and 0 = read.
REQ-010 The module SHALL have port cmd_wdata, input, width DATA_WIDTH, meaning the write data.
REQ-011 The module SHALL have port cmd_strb, input, width DATA_WIDTH/8, meaning the write byte strobes.
REQ-012 The module SHALL have port cmd_prot, input, width 3, meaning the protection attributes.
REQ-013 The module SHALL have port rsp_valid, output, width 1, meaning a completion is presented.
REQ-014 The module SHALL have port rsp_ready, input, width 1, meaning the completion is consumed.
REQ-015 The module SHALL have port rsp_rdata, output, width DATA_WIDTH, meaning the read data.
REQ-016 The module SHALL have port rsp_err, output, width 1, meaning a slave error or a timeout.
REQ-017 The module SHALL have ports psel, penable and pwrite, each output, width 1, meaning the APB control signals.
REQ-018 The module SHALL have ports paddr, output, width ADDR_WIDTH, and pwdata, output, width DATA_WIDTH, meaning the APB address and write data.
REQ-019 The module SHALL have ports pstrb, output, width DATA_WIDTH/8, and pprot, output, width 3, meaning the APB strobes and protection.
REQ-020 The module SHALL have ports prdata, input, width DATA_WIDTH; pready, input, width 1; and pslverr, input, width 1, meaning the APB slave response.

Function
REQ-021 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP; it SHALL handle one outstanding transfer and SHALL NOT pipeline.
REQ-022 cmd_ready SHALL be 1 only in IDLE.
REQ-023 When cmd_valid=1 in IDLE, the command SHALL be captured into registers and the FSM SHALL go to SETUP on the next edge.
REQ-024 In SETUP, psel=1, penable=0, and paddr/pwrite/pwdata/pprot SHALL come from the captured command; the FSM SHALL go to ACCESS after exactly 1 cycle.
REQ-025 In ACCESS, psel=1 and penable=1, and all APB outputs SHALL be held stable until pready=1.
REQ-026 On pready=1 in ACCESS:
- prdata SHALL be latched into rsp_rdata on reads; rsp_rdata SHALL be 0 on writes.
- pslverr SHALL be latched into rsp_err.
- psel and penable SHALL drop.
- The FSM SHALL go to RESP.
REQ-027 pstrb SHALL equal the captured cmd_strb for writes and SHALL be all-zero for reads.
REQ-028 In RESP, rsp_valid SHALL be 1 with rsp_rdata/rsp_err stable; on rsp_ready=1 the FSM SHALL go to IDLE.
REQ-029 The minimum command-accept to rsp_valid latency SHALL be 3 cycles (IDLE→SETUP→ACCESS→RESP, with pready=1 in the first ACCESS cycle).
REQ-030 The next command SHALL NOT be accepted in the same cycle that the response is consumed; back-to-back transfers SHALL have at least one IDLE cycle between them.
REQ-031 Outside SETUP and ACCESS, psel=0 and penable=0, and paddr/pwdata SHALL hold their last value.

Reset
REQ-032 While preset=1 at a pclk edge, the FSM SHALL enter IDLE, and the following outputs SHALL be 0: psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, rsp_rdata, rsp_err and the timeout counter.
REQ-033 Reset asserted mid-transfer (in SETUP, ACCESS or RESP) SHALL abort the transfer with no response generated; cmd_ready SHALL be 0 while preset=1.

Configuration
REQ-034 The macro APB_MASTER_TIMEOUT_EN SHALL compile in an ACCESS-state counter that starts at 0 on entry to ACCESS and increments each cycle pready=0.
REQ-035 With APB_MASTER_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES with pready=0:
- psel and penable SHALL drop.
- The FSM SHALL go to RESP with rsp_err=1 and rsp_rdata=0.
- If pready=1 arrives in that same cycle, normal completion SHALL win.
REQ-036 With APB_MASTER_TIMEOUT_EN undefined, no counter SHALL exist and ACCESS SHALL wait indefinitely for pready.

Verification
REQ-037 The bench SHALL cover: write addr 0x10, wdata 0xA5A5_1234, strb 0xF, with pready=1 immediately → SETUP 1 cycle, ACCESS 1 cycle, pstrb=0xF, rsp_valid on the 3rd cycle after accept, rsp_err=0.
REQ-038 The bench SHALL cover: read addr 0x20, slave inserts 2 wait cycles, prdata=0x0000_0008 → ACCESS lasts 3 cycles with the APB signals stable, pstrb=0, rsp_rdata=0x0000_0008.
REQ-039 The bench SHALL cover: read addr 0x400, slave returns pslverr=1 and prdata=0xDEAD_BEEF → rsp_err=1, rsp_rdata=0xDEAD_BEEF.
REQ-040 The bench SHALL cover: rsp_ready held 0 for 4 cycles → rsp_valid and data stable for 4 cycles, cmd_ready=0, then return to IDLE.
REQ-041 The bench SHALL cover, with APB_MASTER_TIMEOUT_EN defined and pready never asserted → abort after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0; and preset=1 in ACCESS → psel=0 on the next edge with no rsp_valid.

Source files
------------

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding command-to-APB master bridge
// Optional ACCESS timeout compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    preset,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic                    cmd_write,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] ACCESS = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    logic [1:0]            state_q, state_d;
    logic                  psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [STRB_WIDTH-1:0] pstrb_q, pstrb_d;
    logic [2:0]            pprot_q, pprot_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 timeout_hit;

    // Abort on the TIMEOUT_CYCLES-th ACCESS cycle that still lacks pready.
    assign timeout_hit = (cnt_q == CNT_WIDTH'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        state_d     = state_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;
        pprot_d     = pprot_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    paddr_d  = cmd_addr;
                    pwrite_d = cmd_write;
                    pwdata_d = cmd_wdata;
                    pstrb_d  = cmd_write ? cmd_strb : '0;
                    pprot_d  = cmd_prot;
                    psel_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                penable_d = 1'b1;
                state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                cnt_d     = '0;
`endif
            end
            ACCESS: begin
                if (pready) begin
                    rsp_rdata_d = pwrite_q ? '0 : prdata;
                    rsp_err_d   = pslverr;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end
`ifdef APB_MASTER_TIMEOUT_EN
                else if (timeout_hit) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_valid_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            pprot_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
            pprot_q     <= pprot_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef APB_MASTER_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    // Held low during reset so no command slips in while the FSM is forced idle.
    assign cmd_ready = (state_q == IDLE) && !preset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign psel      = psel_q;
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign pprot     = pprot_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scoreboard bench for apb_master
module tb_apb_master;

    logic        pclk = 1'b0;
    logic        preset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic        cmd_write;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_vec = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];

    always #5 pclk = ~pclk;

    apb_master dut (
        .pclk(pclk), .preset(preset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
        .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_pop_compare();
        logic [32:0] e;
        if (exp_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = exp_q.pop_front();
            check("rsp_rdata", 64'(rsp_rdata), 64'(e[32:1]));
            check("rsp_err", 64'(rsp_err), 64'(e[0]));
        end
    endtask

    task automatic consume();
        rsp_ready = 1'b1;
        check("cmd_ready_in_consume", 64'(cmd_ready), 64'd0);
        @(negedge pclk);
        rsp_ready = 1'b0;
        check("rsp_valid_after_consume", 64'(rsp_valid), 64'd0);
        check("cmd_ready_idle", 64'(cmd_ready), 64'd1);
        check("psel_idle", 64'(psel), 64'd0);
    endtask

    task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                        input logic [3:0] strb, input logic [2:0] prot, input int waits,
                        input logic [31:0] rdata, input logic serr, input int hold);
        logic [3:0]  exp_strb;
        logic [31:0] held_rdata;
        logic        held_err;
        exp_strb = wr ? strb : 4'h0;
        @(negedge pclk);
        check("cmd_ready_pre", 64'(cmd_ready), 64'd1);
        cmd_valid = 1'b1; cmd_addr = addr; cmd_write = wr;
        cmd_wdata = wdata; cmd_strb = strb; cmd_prot = prot;
        exp_q.push_back({wr ? 32'h0 : rdata, serr});
        @(negedge pclk);
        cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom;
        check("setup_psel", 64'(psel), 64'd1);
        check("setup_penable", 64'(penable), 64'd0);
        check("setup_paddr", 64'(paddr), 64'(addr));
        check("setup_pwrite", 64'(pwrite), 64'(wr));
        check("setup_pwdata", 64'(pwdata), 64'(wdata));
        check("setup_pstrb", 64'(pstrb), 64'(exp_strb));
        check("setup_pprot", 64'(pprot), 64'(prot));
        check("setup_cmd_ready", 64'(cmd_ready), 64'd0);
        for (int i = 0; i <= waits; i++) begin
            @(negedge pclk);
            check("access_psel", 64'(psel), 64'd1);
            check("access_penable", 64'(penable), 64'd1);
            check("access_paddr", 64'(paddr), 64'(addr));
            check("access_pwdata", 64'(pwdata), 64'(wdata));
            check("access_pstrb", 64'(pstrb), 64'(exp_strb));
            check("access_rsp_valid", 64'(rsp_valid), 64'd0);
            pready  = (i == waits);
            prdata  = (i == waits) ? rdata : $urandom;
            pslverr = (i == waits) ? serr : 1'b1;
        end
        @(negedge pclk);
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
        check("resp_rsp_valid", 64'(rsp_valid), 64'd1);
        check("resp_psel", 64'(psel), 64'd0);
        check("resp_penable", 64'(penable), 64'd0);
        check("resp_paddr_held", 64'(paddr), 64'(addr));
        sb_pop_compare();
        held_rdata = wr ? 32'h0 : rdata;
        held_err   = serr;
        for (int h = 0; h < hold; h++) begin
            @(negedge pclk);
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_rdata", 64'(rsp_rdata), 64'(held_rdata));
            check("hold_rsp_err", 64'(rsp_err), 64'(held_err));
            check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
        end
        consume();
    endtask

    initial begin
        int n;
        preset = 1'b1; cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0;
        cmd_wdata = '0; cmd_strb = '0; cmd_prot = '0; rsp_ready = 1'b0;
        prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (3) @(negedge pclk);
        check("rst_psel", 64'(psel), 64'd0);
        check("rst_penable", 64'(penable), 64'd0);
        check("rst_pwrite", 64'(pwrite), 64'd0);
        check("rst_paddr", 64'(paddr), 64'd0);
        check("rst_pwdata", 64'(pwdata), 64'd0);
        check("rst_pstrb", 64'(pstrb), 64'd0);
        check("rst_pprot", 64'(pprot), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
        check("rst_rsp_err", 64'(rsp_err), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        preset = 1'b0;

        xfer(32'h10, 1'b1, 32'hA5A5_1234, 4'hF, 3'd2, 0, 32'h0, 1'b0, 0);
        xfer(32'h20, 1'b0, 32'h1111_2222, 4'hF, 3'd1, 2, 32'h0000_0008, 1'b0, 0);
        xfer(32'h400, 1'b0, 32'h0, 4'h3, 3'd5, 0, 32'hDEAD_BEEF, 1'b1, 0);
        xfer(32'h88, 1'b0, 32'h0, 4'h0, 3'd7, 1, 32'h1234_5678, 1'b0, 4);
        xfer(32'hC, 1'b1, 32'h0BAD_F00D, 4'h5, 3'd0, 3, 32'hFFFF_FFFF, 1'b1, 2);

        // Timeout behaviour depends on build configuration.
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_addr = 32'h30; cmd_write = 1'b0; cmd_prot = 3'd0;
        @(negedge pclk);
        cmd_valid = 1'b0;
`ifdef APB_MASTER_TIMEOUT_EN
        exp_q.push_back({32'h0, 1'b1});
        prdata = 32'hCAFE_CAFE;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge pclk);
            if (rsp_valid) break;
            if (penable) n++;
        end
        check("timeout_access_cycles", 64'(n), 64'd16);
        check("timeout_rsp_valid", 64'(rsp_valid), 64'd1);
        check("timeout_psel", 64'(psel), 64'd0);
        sb_pop_compare();
        consume();
`else
        n = 0;
        repeat (40) begin
            @(negedge pclk);
            if (rsp_valid) n++;
        end
        check("no_timeout_rsp_valid", 64'(n), 64'd0);
        check("no_timeout_penable", 64'(penable), 64'd1);
        pready = 1'b1; prdata = 32'h0000_0077;
        exp_q.push_back({32'h0000_0077, 1'b0});
        @(negedge pclk);
        pready = 1'b0;
        check("late_rsp_valid", 64'(rsp_valid), 64'd1);
        sb_pop_compare();
        consume();
`endif

        // Reset in ACCESS aborts with no response.
        @(negedge pclk);
        cmd_valid = 1'b1; cmd_addr = 32'h50; cmd_write = 1'b1; cmd_wdata = 32'h5555_AAAA;
        @(negedge pclk);
        cmd_valid = 1'b0;
        @(negedge pclk);
        check("abort_in_access", 64'(penable), 64'd1);
        preset = 1'b1;
        @(negedge pclk);
        check("abort_psel", 64'(psel), 64'd0);
        check("abort_penable", 64'(penable), 64'd0);
        check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd0);
        check("abort_paddr", 64'(paddr), 64'd0);
        preset = 1'b0;
        n = 0;
        repeat (3) begin
            @(negedge pclk);
            if (rsp_valid) n++;
        end
        check("abort_no_rsp", 64'(n), 64'd0);
        check("abort_cmd_ready_after", 64'(cmd_ready), 64'd1);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
